// File: rtl/input_conditioner.sv
// input_conditioner
//   Turns raw, asynchronous, bouncing board inputs into the clean synchronous
//   signals the calculator control FSM samples.
//   - Every raw bit passes through a 2-flop synchroniser.
//   - Each button is debounced into a stable level.
//   - A single-cycle pulse is produced on each accepted press.
//   - The 3-bit switch bus is debounced as a unit into MS.
//
// Ports
//   CLK           system clock, rising edge
//   RST_n         asynchronous active-low reset
//   btn_go_raw    raw Go button
//   btn_next_raw  raw Next button
//   sw_ms_raw     raw operation-select switches [2:0]
//   Go            one-cycle pulse per accepted Go press
//   next          one-cycle pulse per accepted Next press (loses to Go on collision)
//   MS            debounced operation code; frozen while next is high
//   go_level      debounced Go level
//   next_level    debounced Next level

// ic_debounce
//   One debounce channel of width W. A new level is accepted only after
//   DB_CYCLES consecutive mismatching samples. Any sample equal to the stable
//   value restarts the count. While hold is high, the counter and the stable
//   value are both frozen.
//
// Ports
//   clk, rst_n    clock and asynchronous active-low reset
//   hold          freeze counter and stable value
//   din           synchronised input
//   stable        debounced value
//   rise_d        stable will go 0->1 on this edge (meaningful for W == 1)
module ic_debounce #(
    parameter int W         = 1,
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable,
    output logic         rise_d
);
    localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

    logic [W-1:0]    stable_d, stable_q;
    logic [DB_W-1:0] cnt_d, cnt_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (!hold) begin
            if (din != stable_q) begin
                if (cnt_q == LAST) begin
                    stable_d = din;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise_d = stable_d[0] & ~stable_q[0];
endmodule

module input_conditioner #(
    parameter int DB_CYCLES = 250000,
    parameter int DB_W      = 18
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       btn_go_raw,
    input  logic       btn_next_raw,
    input  logic [2:0] sw_ms_raw,
    output logic       Go,
    output logic       next,
    output logic [2:0] MS,
    output logic       go_level,
    output logic       next_level
);
    localparam int NUM_BTN = 2;  // lane 0 = Go, lane 1 = Next

    // Synchroniser layout: {sw_ms[2:0], next, go}
    logic [4:0] sync1_q, sync2_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {sw_ms_raw, btn_next_raw, btn_go_raw};
            sync2_q <= sync1_q;
        end
    end

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        ic_debounce #(.W(1), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
            .clk    (CLK),
            .rst_n  (RST_n),
            .hold   (1'b0),
            .din    (sync2_q[i]),
            .stable (btn_level[i]),
            .rise_d (btn_rise[i])
        );
    end

    logic go_pulse_d, go_pulse_q;
    logic next_pulse_d, next_pulse_q;

    // Go wins a same-edge collision; the Next pulse is simply dropped.
    always_comb begin
        go_pulse_d   = btn_rise[0];
        next_pulse_d = btn_rise[1] & ~btn_rise[0];
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            go_pulse_q   <= 1'b0;
            next_pulse_q <= 1'b0;
        end else begin
            go_pulse_q   <= go_pulse_d;
            next_pulse_q <= next_pulse_d;
        end
    end

    // MS is frozen while next is high so the FSM sees a constant code
    // in the cycle it samples next.
    logic ms_rise_unused;

    ic_debounce #(.W(3), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_ms (
        .clk    (CLK),
        .rst_n  (RST_n),
        .hold   (next_pulse_q),
        .din    (sync2_q[4:2]),
        .stable (MS),
        .rise_d (ms_rise_unused)
    );

    assign Go         = go_pulse_q;
    assign next       = next_pulse_q;
    assign go_level   = btn_level[0];
    assign next_level = btn_level[1];
endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 3;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       btn_go_raw, btn_next_raw;
    logic [2:0] sw_ms_raw;
    logic       Go, next, go_level, next_level;
    logic [2:0] MS;

    int checks = 0;
    int errors = 0;

    input_conditioner #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .btn_go_raw   (btn_go_raw),
        .btn_next_raw (btn_next_raw),
        .sw_ms_raw    (sw_ms_raw),
        .Go           (Go),
        .next         (next),
        .MS           (MS),
        .go_level     (go_level),
        .next_level   (next_level)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle; samples and drives happen here.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        RST_n = 1'b0; btn_go_raw = 1'b0; btn_next_raw = 1'b0; sw_ms_raw = 3'b000;
        idle(2);
        checks++;
        if ({Go, next, MS, go_level, next_level} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000000", {Go, next, MS, go_level, next_level});
        end
        RST_n = 1'b1;
        idle(2);
    endtask

    // Rise before edge 0: Go pulses only after edge 5, level from edge 5.
    task automatic test_clean_press();
        btn_go_raw = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (Go !== (n == 5)) begin
                errors++;
                $display("FAIL clean_go edge %0d: got %b want %b", n, Go, (n == 5));
            end
            checks++;
            if (go_level !== (n >= 5)) begin
                errors++;
                $display("FAIL clean_level edge %0d: got %b want %b", n, go_level, (n >= 5));
            end
        end
        btn_go_raw = 1'b0;
        idle(10);
        checks++;
        if ({Go, go_level} !== 2'b00) begin
            errors++;
            $display("FAIL clean_release: got %b want 00", {Go, go_level});
        end
    endtask

    // Raw 1,0,1,1,0 then 1 from edge 5: single pulse after edge 10.
    task automatic test_bounce();
        logic [4:0] pat;
        pat = 5'b01101;  // bit j = value before edge j
        for (int n = 0; n < 16; n++) begin
            btn_next_raw = (n < 5) ? pat[n] : 1'b1;
            tick();
            checks++;
            if (next !== (n == 10)) begin
                errors++;
                $display("FAIL bounce_next edge %0d: got %b want %b", n, next, (n == 10));
            end
        end
        btn_next_raw = 1'b0;
        idle(10);
    endtask

    // Three high cycles only: never accepted.
    task automatic test_glitch();
        for (int n = 0; n < 12; n++) begin
            btn_go_raw = (n < 3);
            tick();
            checks++;
            if ({Go, go_level} !== 2'b00) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b want 00", n, {Go, go_level});
            end
        end
    endtask

    task automatic test_collision();
        btn_go_raw = 1'b1; btn_next_raw = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if ({Go, next} !== {(n == 5), 1'b0}) begin
                errors++;
                $display("FAIL collide edge %0d: got Go,next=%b want %b", n, {Go, next}, {(n == 5), 1'b0});
            end
        end
        checks++;
        if (next_level !== 1'b1) begin
            errors++;
            $display("FAIL collide_level: got %b want 1", next_level);
        end
        btn_go_raw = 1'b0; btn_next_raw = 1'b0;
        idle(10);
        btn_next_raw = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (next !== (n == 5)) begin
                errors++;
                $display("FAIL collide_later edge %0d: got %b want %b", n, next, (n == 5));
            end
        end
        btn_next_raw = 1'b0;
        idle(10);
    endtask

    // Next pulse after edge 5; MS accept would fall on edge 6, deferred to 7.
    task automatic test_ms_hold();
        sw_ms_raw = 3'b001;
        idle(10);
        checks++;
        if (MS !== 3'b001) begin
            errors++;
            $display("FAIL ms_init: got %b want 001", MS);
        end
        btn_next_raw = 1'b1;
        for (int n = 0; n < 11; n++) begin
            if (n == 1) sw_ms_raw = 3'b011;
            tick();
            checks++;
            if (next !== (n == 5)) begin
                errors++;
                $display("FAIL ms_next edge %0d: got %b want %b", n, next, (n == 5));
            end
            checks++;
            if (MS !== ((n >= 7) ? 3'b011 : 3'b001)) begin
                errors++;
                $display("FAIL ms_hold edge %0d: got %b want %b", n, MS, ((n >= 7) ? 3'b011 : 3'b001));
            end
        end
        btn_next_raw = 1'b0;
        idle(10);
    endtask

    task automatic test_reset_mid();
        btn_go_raw = 1'b1;
        idle(4);             // edges 0..3: go counter now 2
        RST_n = 1'b0;
        #1;
        checks++;
        if ({Go, next, MS, go_level, next_level} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid: got %b want 0000000", {Go, next, MS, go_level, next_level});
        end
        idle(2);
        RST_n = 1'b1;        // next edge is the first where sync1 samples 1
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (Go !== (n == 5)) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %b want %b", n, Go, (n == 5));
            end
        end
        btn_go_raw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_collision();
        test_ms_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage of the calculator control path. Converts the raw Go and Next push buttons and the 3-bit operation-select switches into the clean, synchronous signals the control FSM samples: debounced single-cycle Go/next pulses and a stable MS code. Sits between the board I/O pins and the FSM's Go, next and MS inputs. Without it, a held button would advance the FSM through several states in consecutive cycles.

## Interface
- DB_CYCLES, 250000: consecutive stable cycles required to accept a new input level (2.5 ms at 100 MHz). Must be ≥ 2.
- DB_W, 18: width of each debounce counter. Must satisfy 2^DB_W > DB_CYCLES.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- btn_go_raw  in  1  raw Go button, asynchronous, bouncing.
- btn_next_raw  in  1  raw Next button, asynchronous, bouncing.
- sw_ms_raw  in  3  raw operation-select switches, asynchronous.
- Go  out  1  one-cycle pulse on each accepted Go press.
- next  out  1  one-cycle pulse on each accepted Next press.
- MS  out  3  debounced operation code.
- go_level  out  1  debounced Go button level, for the LED.
- next_level  out  1  debounced Next button level, for the LED.

Clocking and reset are fixed: one clock; reset is asynchronous and active-low (CLK, RST_n).

## Operation
- **Synchronisers**
  - Each raw input, including each of the 3 switch bits, passes through a 2-flop synchroniser (sync1, then sync2).
  - Only sync2 values feed the logic below.
- **Button channel** (one each for Go and Next)
  - Holds a stable level and a DB_W-bit counter.
  - On each edge where sync2 ≠ stable:
    - If counter = DB_CYCLES−1: stable ← sync2 and counter ← 0.
    - Otherwise: counter ← counter+1.
  - On each edge where sync2 = stable: counter ← 0.
  - Any bounce back to the old level therefore restarts the count.
- **Pulse generation**
  - The pulse register loads 1 on the edge where stable goes 0→1, and loads 0 on every other edge.
  - A 1→0 transition (button release) produces no pulse.
  - A press must be released and debounced before another pulse can occur.
- **Go/next collision**
  - If both channels would pulse on the same edge, Go pulses and the next pulse is dropped. It is not queued.
- **MS channel**
  - The 3-bit sync2 bus is debounced as a unit against the registered MS value, using the counter rule above.
  - Any bit change restarts the count.
  - While next is high, the MS counter holds and MS does not update. This guarantees MS is constant in the cycle the FSM samples next.
- **Level outputs**
  - go_level and next_level equal the respective stable registers.

## Timing
- **Reset** (asynchronous; all outputs 0)
  - Go=0, next=0, MS=000, go_level=0, next_level=0.
  - All sync flops, stable registers and counters are cleared.
  - Reset asserted mid-count discards the partial count.
- **Button held through reset release:** this is treated as a new press. A pulse follows after the normal latency.
- **Press latency**
  - Raw input first sampled high at edge k, and stable thereafter: sync2=1 after edge k+1, stable=1 after edge k+DB_CYCLES+1.
  - The pulse is high from edge k+DB_CYCLES+1 to edge k+DB_CYCLES+2: exactly one cycle.
- **MS latency:** a new switch value sampled at edge k appears on MS after edge k+DB_CYCLES+1. If next is high during this window, the update is deferred by the hold cycles.
- **Glitch rejection:** a mismatch lasting ≤ DB_CYCLES−1 consecutive cycles never changes stable or MS.
- **Throughput:** minimum spacing between two pulses on the same channel is 2·DB_CYCLES cycles (press accepted, release accepted, press accepted).
- **Counter wrap:** the counter never exceeds DB_CYCLES−1, so it never wraps.

## Test plan
- **Clean press** (DB_CYCLES=4): btn_go_raw rises before edge 0 and is held for 20 cycles → Go=1 only between edges 5 and 6; go_level=1 from edge 5 onward; no further Go pulse while held.
- **Bouncing press** (DB_CYCLES=4): btn_next_raw toggles 1,0,1,1,0 over 5 cycles, then stays 1 → no pulse during the bounce; exactly one next pulse, DB_CYCLES+1 edges after the final rise.
- **Glitch** (DB_CYCLES=4): btn_go_raw high for 3 cycles, then low → Go never asserts; go_level stays 0.
- **Collision:** both buttons rise on the same cycle and are held → Go pulses once; next never pulses for that press; next pulses normally on a later press.
- **MS hold:** sw_ms_raw changes 001→011 so that its acceptance edge falls inside a next pulse → MS=001 while next=1; MS=011 one edge after next falls.
- **Reset mid-operation:** assert RST_n=0 at counter=2 with Go held → all outputs 0 immediately. Release reset with Go still held → a Go pulse DB_CYCLES+1 edges after the first edge at which sync1 samples 1.
